cmd_dispatch: RTL and testbench
===============================

// Module: cmd_dispatch
// PURPOSE
//  Command sequencer for the DSO UART link. Takes each 24-bit host command from the UART
//  command receiver (cmd/cmd_rdy) and acknowledges it with clr_cmd_rdy.
//  It then executes the command against a config register file or the sample capture RAM.
//  Responses go out as single bytes through the UART transmitter (trmt/tx_data/tx_done).
//  It is the only master of trmt; it sits between the UART pair and the DSO core.
// PARAMETERS
//  NUM_REGS    8      number of 8-bit config registers (1..256)
//  DUMP_DEPTH  256    capture RAM depth in bytes; power of 2; AW = $clog2(DUMP_DEPTH)
//  ACK_BYTE    8'hA5  positive acknowledge byte
//  NAK_BYTE    8'hEE  negative acknowledge byte
// PORTS
//  clk          in   1            system clock
//  rst_n        in   1            asynchronous active-low reset
//  cmd_rdy      in   1            command-valid flag from the UART receiver
//  cmd          in   24           [23:16] opcode, [15:8] addr, [7:0] data
//  clr_cmd_rdy  out  1            1-cycle pulse; the command has been taken
//  trmt         out  1            1-cycle pulse; start a TX byte
//  tx_data      out  8            byte to transmit; stable from trmt until tx_done
//  tx_done      in   1            TX frame complete
//  mem_rd_en    out  1            capture RAM read strobe
//  mem_addr     out  AW           capture RAM address
//  mem_rdata    in   8            RAM read data; valid the cycle after mem_rd_en
//  cfg_regs     out  8*NUM_REGS   flat register file; reg i is [8i+7:8i]
//  busy         out  1            1 whenever the state is not IDLE
// BEHAVIOUR
//  Reset values: every output is 0, all regs are 0, state is IDLE.
//  States: IDLE, EXEC, MEM_RD, MEM_WAIT, SEND, WAIT_TX.
//  IDLE, cmd_rdy=1 at cycle N:
//   - N+1: latch cmd, pulse clr_cmd_rdy, go to EXEC.
//   - N+2: for WR/RD/illegal, trmt=1 with tx_data set, then WAIT_TX.
//  Opcodes:
//   - 0x01 WR: if addr<NUM_REGS, regs[addr]<=data in EXEC and reply ACK_BYTE.
//   - 0x02 RD: if addr<NUM_REGS, reply regs[addr].
//   - Any out-of-range addr: reply NAK_BYTE; no register changes.
//   - 0x03 DUMP: start address = addr; count = data+1 (1..256); no trailing ACK.
//     Path per byte: MEM_RD (mem_rd_en=1) -> MEM_WAIT (capture mem_rdata) -> SEND (trmt) -> WAIT_TX.
//     mem_addr increments modulo DUMP_DEPTH, so it wraps from DUMP_DEPTH-1 to 0.
//   - Any other opcode: reply NAK_BYTE.
//  WAIT_TX:
//   - Waits for a 0->1 edge of tx_done (registered edge detect); a level held from a
//     previous byte is ignored.
//   - Then goes to MEM_RD if dump bytes remain, otherwise to IDLE.
//  tx_data holds its value until the next trmt.
//  cmd_rdy asserted while busy: stays pending, is not cleared, and is serviced on return to IDLE.
//  Back-to-back commands: IDLE lasts at least 1 cycle between commands.
//  rst_n low mid-operation: immediate return to reset values; an in-flight byte or dump is abandoned.
// CONFIGURATION
//  CMD_DUMP_EN defined: opcode 0x03 behaves as above; the mem_* ports are driven.
//  CMD_DUMP_EN undefined:
//   - 0x03 is illegal and replies NAK_BYTE.
//   - MEM_RD and MEM_WAIT are removed.
//   - mem_rd_en and mem_addr are tied to 0.
// STRUCTURE
//  Package dso_cmd_pkg holds:
//   - opcode enum (OP_WR=8'h01, OP_RD=8'h02, OP_DUMP=8'h03)
//   - state enum
//   - ACK/NAK defaults
//  Sub-module cfg_regfile:
//   - NUM_REGS x 8 flops, async reset to 0
//   - write port (we, waddr, wdata), combinational read port, flat cfg_regs out
//  The FSM, dump counter, address counter and tx_done edge detect stay in cmd_dispatch.
// TESTING
//  1. cmd=24'h01035A -> one clr_cmd_rdy pulse; regs[3]=8'h5A; one trmt with tx_data=8'hA5.
//  2. After (1), cmd=24'h020300 -> one trmt with tx_data=8'h5A; regs unchanged.
//  3. cmd=24'h0108FF (NUM_REGS=8) -> tx_data=8'hEE; all regs unchanged.
//     cmd=24'h7F0000 -> tx_data=8'hEE.
//  4. CMD_DUMP_EN, DUMP_DEPTH=256, RAM[a]=a^8'h3C, cmd=24'h03FE02:
//     - mem_addr sequence FE, FF, 00
//     - tx_data sequence C2, C3, 3C; exactly 3 trmt pulses, then IDLE
//  5. Second cmd_rdy raised during the dump in (4): no clr_cmd_rdy until the dump ends.
//     Then it is serviced normally.
//  6. rst_n low between byte 1 and byte 2 of a dump: all outputs and regs go to 0, state IDLE.
//     No further trmt after rst_n returns high.

Source files
------------

// File: rtl/dso_cmd_pkg.sv
// Shared opcodes, FSM state encodings and command layout for the DSO UART command sequencer.
// Optional dump support is enabled in cmd_dispatch by defining CMD_DUMP_EN.
package dso_cmd_pkg;

    typedef enum logic [7:0] {
        OP_WR   = 8'h01,
        OP_RD   = 8'h02,
        OP_DUMP = 8'h03
    } op_e;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_EXEC     = 3'd1;
    localparam state_t S_MEM_RD   = 3'd2;
    localparam state_t S_MEM_WAIT = 3'd3;
    localparam state_t S_SEND     = 3'd4;
    localparam state_t S_WAIT_TX  = 3'd5;

    localparam logic [7:0] ACK_DEF = 8'hA5;
    localparam logic [7:0] NAK_DEF = 8'hEE;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

endpackage

// File: rtl/cmd_dispatch_regfile.sv
// Config register file: NUM_REGS x 8 flops, one write port, one combinational read port.
// Addresses at or above NUM_REGS read as 0 and never write.
module cfg_regfile
    import dso_cmd_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [7:0]            waddr,
    input  logic [7:0]            wdata,
    input  logic [7:0]            raddr,
    output logic [7:0]            rdata,
    output logic [8*NUM_REGS-1:0] cfg_regs
);

    logic [NUM_REGS-1:0][7:0] r_regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
        end else if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (waddr == 8'(i)) r_regs[i] <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr == 8'(i)) rdata = r_regs[i];
        end
    end

    assign cfg_regs = r_regs;

endmodule

// File: rtl/cmd_dispatch.sv
// Host command sequencer between the UART pair and the DSO core (regs + capture RAM dump).
// Define CMD_DUMP_EN to enable opcode 0x03 capture RAM dumps.
module cmd_dispatch
    import dso_cmd_pkg::*;
#(
    parameter int         NUM_REGS   = 8,
    parameter int         DUMP_DEPTH = 256,
    parameter logic [7:0] ACK_BYTE   = ACK_DEF,
    parameter logic [7:0] NAK_BYTE   = NAK_DEF,
    localparam int        AW         = $clog2(DUMP_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_rdy,
    input  logic [23:0]           cmd,
    output logic                  clr_cmd_rdy,
    output logic                  trmt,
    output logic [7:0]            tx_data,
    input  logic                  tx_done,
    output logic                  mem_rd_en,
    output logic [AW-1:0]         mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic [8*NUM_REGS-1:0] cfg_regs,
    output logic                  busy
);

    cmd_t       r_cmd;
    state_t     r_state;
    logic       r_clr;
    logic       r_trmt;
    logic       r_tx_done_d;
    logic [7:0] r_tx_data;

    logic       w_addr_ok;
    logic       w_we;
    logic       w_tx_rise;
    logic [7:0] w_rdata;
    logic [7:0] w_reply;

    assign w_addr_ok = (32'(r_cmd.addr) < NUM_REGS);
    assign w_we      = (r_state == S_EXEC) && (r_cmd.op == OP_WR) && w_addr_ok;
    // Only a fresh rising edge ends WAIT_TX, so a stale high level is ignored.
    assign w_tx_rise = tx_done & ~r_tx_done_d;

    cfg_regfile #(
        .NUM_REGS(NUM_REGS)
    ) u_regs (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (w_we),
        .waddr   (r_cmd.addr),
        .wdata   (r_cmd.data),
        .raddr   (r_cmd.addr),
        .rdata   (w_rdata),
        .cfg_regs(cfg_regs)
    );

    always_comb begin
        w_reply = NAK_BYTE;
        case (r_cmd.op)
            OP_WR:   if (w_addr_ok) w_reply = ACK_BYTE;
            OP_RD:   if (w_addr_ok) w_reply = w_rdata;
            default: w_reply = NAK_BYTE;
        endcase
    end

`ifdef CMD_DUMP_EN
    logic [AW-1:0] r_addr;
    logic [7:0]    r_cnt;
    logic [7:0]    r_byte;

    assign mem_rd_en = (r_state == S_MEM_RD);
    assign mem_addr  = r_addr;
`else
    logic w_unused_rdata;

    assign mem_rd_en      = 1'b0;
    assign mem_addr       = '0;
    assign w_unused_rdata = ^mem_rdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd       <= '0;
            r_state     <= S_IDLE;
            r_clr       <= 1'b0;
            r_trmt      <= 1'b0;
            r_tx_done_d <= 1'b0;
            r_tx_data   <= '0;
`ifdef CMD_DUMP_EN
            r_addr      <= '0;
            r_cnt       <= '0;
            r_byte      <= '0;
`endif
        end else begin
            r_clr       <= 1'b0;
            r_trmt      <= 1'b0;
            r_tx_done_d <= tx_done;
            case (r_state)
                S_IDLE: begin
                    if (cmd_rdy) begin
                        r_cmd   <= cmd;
                        r_clr   <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
`ifdef CMD_DUMP_EN
                    // r_cnt holds the bytes left after the current one.
                    if (r_cmd.op == OP_DUMP) begin
                        r_addr  <= AW'(r_cmd.addr);
                        r_cnt   <= r_cmd.data;
                        r_state <= S_MEM_RD;
                    end else
`endif
                    begin
                        r_trmt    <= 1'b1;
                        r_tx_data <= w_reply;
                        r_state   <= S_WAIT_TX;
                    end
                end
`ifdef CMD_DUMP_EN
                S_MEM_RD:   r_state <= S_MEM_WAIT;
                S_MEM_WAIT: begin
                    r_byte  <= mem_rdata;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    r_trmt    <= 1'b1;
                    r_tx_data <= r_byte;
                    r_state   <= S_WAIT_TX;
                end
`endif
                S_WAIT_TX: begin
                    if (w_tx_rise) begin
`ifdef CMD_DUMP_EN
                        if (r_cmd.op == OP_DUMP && r_cnt != 8'd0) begin
                            r_cnt   <= r_cnt - 8'd1;
                            r_addr  <= r_addr + 1'b1;
                            r_state <= S_MEM_RD;
                        end else
`endif
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign clr_cmd_rdy = r_clr;
    assign trmt        = r_trmt;
    assign tx_data     = r_tx_data;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch: vector table, TX byte scoreboard, dump and reset sequences.
// Dump sequences are exercised when CMD_DUMP_EN is defined; otherwise 0x03 must NAK.
`timescale 1ns/1ps
module tb_cmd_dispatch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_rdy = 1'b0;
    logic [23:0] cmd = '0;
    logic        clr_cmd_rdy;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic [63:0] cfg_regs;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;
    int clr_cnt = 0;
    int trmt_cnt = 0;
    int rd_cnt = 0;
    int tx_ctr = 0;
    logic rose = 1'b0;
    logic busy_q = 1'b0;
    logic [63:0] exp_regs = '0;
    logic [7:0] tx_q[$];
    logic [7:0] addr_q[$];

    typedef struct {
        logic [23:0] c;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[11];

    cmd_dispatch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_rdy    (cmd_rdy),
        .cmd        (cmd),
        .clr_cmd_rdy(clr_cmd_rdy),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .cfg_regs   (cfg_regs),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_addr ^ 8'h3C;
    end

    // Monitor + TX model; tx_done stays high two cycles past trmt to expose level-sensitive exits.
    always @(negedge clk) begin
        if (!rst_n) begin
            tx_done = 1'b0;
            tx_ctr  = 0;
            rose    = 1'b0;
            busy_q  = 1'b0;
        end else begin
            if (busy_q && !busy) check("busy_end_after_tx_rise", rose, 1);
            busy_q = busy;
            if (clr_cmd_rdy) clr_cnt++;
            if (mem_rd_en) begin
                rd_cnt++;
                if (addr_q.size() > 0) check("mem_addr", mem_addr, addr_q.pop_front());
            end
            if (trmt) begin
                trmt_cnt++;
                if (tx_q.size() == 0) check("unexpected_trmt", 1, 0);
                else check("tx_data", tx_data, tx_q.pop_front());
            end
            rose = 1'b0;
            if (trmt) begin
                tx_ctr = 6;
            end else if (tx_ctr > 0) begin
                tx_ctr--;
                if (tx_ctr == 4) tx_done = 1'b0;
                if (tx_ctr == 0) begin
                    tx_done = 1'b1;
                    rose    = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 2000 && busy; i++) tick();
        check({nm, "_idle_timeout"}, busy, 0);
    endtask

    task automatic issue(input logic [23:0] c, input string nm);
        int c0 = clr_cnt;
        cmd     = c;
        cmd_rdy = 1'b1;
        for (int i = 0; i < 100 && clr_cnt == c0; i++) tick();
        check({nm, "_clr_timeout"}, clr_cnt - c0, 1);
        cmd_rdy = 1'b0;
    endtask

    task automatic run_vec(input logic [23:0] c, input logic [7:0] exp, input string nm);
        int c0 = clr_cnt;
        int t0 = trmt_cnt;
        tx_q.push_back(exp);
        if (c[23:16] == 8'h01 && c[15:8] < 8) exp_regs[c[15:8]*8 +: 8] = c[7:0];
        issue(c, nm);
        wait_idle(nm);
        tick();
        check({nm, "_clr_pulses"}, clr_cnt - c0, 1);
        check({nm, "_trmt_pulses"}, trmt_cnt - t0, 1);
        check({nm, "_regs"}, cfg_regs, exp_regs);
    endtask

    task automatic reset_checks(input string nm);
        check({nm, "_trmt"}, trmt, 0);
        check({nm, "_clr"}, clr_cmd_rdy, 0);
        check({nm, "_tx_data"}, tx_data, 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_mem_rd_en"}, mem_rd_en, 0);
        check({nm, "_mem_addr"}, mem_addr, 0);
        check({nm, "_regs"}, cfg_regs, 0);
    endtask

    task automatic wait_trmt(input int t0, input string nm);
        for (int i = 0; i < 200 && trmt_cnt == t0; i++) tick();
        check({nm, "_trmt_timeout"}, trmt_cnt - t0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int t0;
        vecs[0]  = '{24'h01035A, 8'hA5};
        vecs[1]  = '{24'h020300, 8'h5A};
        vecs[2]  = '{24'h0108FF, 8'hEE};
        vecs[3]  = '{24'h7F0000, 8'hEE};
        vecs[4]  = '{24'h0107C3, 8'hA5};
        vecs[5]  = '{24'h020700, 8'hC3};
        vecs[6]  = '{24'h020800, 8'hEE};
        vecs[7]  = '{24'h0100FF, 8'hA5};
        vecs[8]  = '{24'h020000, 8'hFF};
        vecs[9]  = '{24'h000000, 8'hEE};
`ifdef CMD_DUMP_EN
        vecs[10] = '{24'h040000, 8'hEE};
`else
        vecs[10] = '{24'h030000, 8'hEE};
`endif

        repeat (3) tick();
        reset_checks("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        for (int v = 0; v < 11; v++) run_vec(vecs[v].c, vecs[v].exp, $sformatf("vec%0d", v));

`ifdef CMD_DUMP_EN
        c0 = clr_cnt;
        t0 = trmt_cnt;
        addr_q = '{8'hFE, 8'hFF, 8'h00};
        tx_q = '{8'hFE ^ 8'h3C, 8'hFF ^ 8'h3C, 8'h00 ^ 8'h3C};
        issue(24'h03FE02, "dump");
        wait_idle("dump");
        tick();
        check("dump_trmt_pulses", trmt_cnt - t0, 3);
        check("dump_addr_left", addr_q.size(), 0);
        check("dump_reads", rd_cnt, 3);

        c0 = clr_cnt;
        t0 = trmt_cnt;
        addr_q = '{8'hFE, 8'hFF, 8'h00};
        tx_q = '{8'hC2, 8'hC3, 8'h3C};
        issue(24'h03FE02, "pend");
        cmd     = 24'h020300;
        cmd_rdy = 1'b1;
        wait_idle("pend_dump");
        check("pend_clr_during_dump", clr_cnt - c0, 1);
        check("pend_trmt_during_dump", trmt_cnt - t0, 3);
        tx_q.push_back(8'h5A);
        for (int i = 0; i < 100 && clr_cnt == c0 + 1; i++) tick();
        cmd_rdy = 1'b0;
        check("pend_serviced_clr", clr_cnt - c0, 2);
        wait_idle("pend_rd");
        tick();
        check("pend_trmt_total", trmt_cnt - t0, 4);

        t0 = trmt_cnt;
        addr_q = '{8'h00};
        tx_q = '{8'h3C};
        issue(24'h030010, "dump_rst");
        wait_trmt(t0, "dump_rst");
        rst_n = 1'b0;
        tick();
        reset_checks("dump_rst");
        addr_q.delete();
        exp_regs = '0;
        rst_n = 1'b1;
        repeat (100) tick();
        check("dump_rst_no_more_trmt", trmt_cnt - t0, 1);
        check("dump_rst_idle", busy, 0);
        run_vec(24'h01035A, 8'hA5, "rewrite");
`endif

        t0 = trmt_cnt;
        tx_q.push_back(8'h5A);
        issue(24'h020300, "rd_rst");
        wait_trmt(t0, "rd_rst");
        rst_n = 1'b0;
        tick();
        reset_checks("rd_rst");
        exp_regs = '0;
        rst_n = 1'b1;
        repeat (50) tick();
        check("rd_rst_no_more_trmt", trmt_cnt - t0, 1);
        run_vec(24'h020300, 8'h00, "post_rst_rd");

        check("tx_queue_empty", tx_q.size(), 0);
`ifndef CMD_DUMP_EN
        check("no_mem_reads", rd_cnt, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
